sopc_mem_arbiter: RTL and testbench

- Sequencing controller that shares one single-port synchronous SRAM between the CPU instruction-fetch port and the data (load/store) port of the minimal SOPC.
- Sits between the core's two bus masters and the on-chip memory.
- Grants one master at a time, holds address and control stable for a programmable number of wait states, returns registered read data with a one-cycle ack, and raises a stall request to the pipeline controller while any master waits.

---
 rtl/sopc_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sopc_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_mem_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store masters.
// Optional: define SOPC_ARB_ROUND_ROBIN_EN to replace fixed data-first priority with round robin.
module sopc_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_sel,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_sel,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_req
);

  localparam int unsigned SelW     = DATA_W / 8;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               r_gnt_d, w_gnt_d_nxt;
  logic               r_mem_ce, w_mem_ce_nxt;
  logic               r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic [SelW-1:0]    r_mem_sel, w_mem_sel_nxt;
  logic [DATA_W-1:0]  r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0]  r_d_rdata, w_d_rdata_nxt;
  logic               r_i_ack, w_i_ack_nxt;
  logic               r_d_ack, w_d_ack_nxt;

  logic               w_any_req;
  logic               w_grant;
  logic               w_pick_d;

  assign w_any_req = i_req | d_req;
  assign w_grant   = (r_state == StIdle) && w_any_req;

`ifdef SOPC_ARB_ROUND_ROBIN_EN
  // Remembers the last winner; reset value (instruction) lets data win the first tie.
  logic r_last_d;

  always_comb begin
    if (i_req && d_req) begin
      w_pick_d = ~r_last_d;
    end else begin
      w_pick_d = d_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (w_any_req) w_state_nxt = StAccess;
      StAccess: if (r_cnt == 4'd0) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Output / datapath next values; everything visible outside is registered below.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_gnt_d_nxt     = r_gnt_d;
    w_mem_ce_nxt    = r_mem_ce;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_sel_nxt   = r_mem_sel;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_i_ack_nxt     = 1'b0;
    w_d_ack_nxt     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_gnt_d_nxt  = w_pick_d;
          w_mem_ce_nxt = 1'b1;
          w_cnt_nxt    = WaitInit;
          if (w_pick_d) begin
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
            w_mem_sel_nxt   = d_sel;
          end else begin
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = i_addr;
            w_mem_wdata_nxt = '0;
            w_mem_sel_nxt   = '1;
          end
        end
      end
      StAccess: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_mem_ce_nxt = 1'b0;
          w_mem_we_nxt = 1'b0;
          if (r_gnt_d) begin
            w_d_ack_nxt = 1'b1;
            // Stores leave the load-data register untouched.
            if (!r_mem_we) w_d_rdata_nxt = mem_rdata;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_gnt_d     <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_gnt_d     <= w_gnt_d_nxt;
      r_mem_ce    <= w_mem_ce_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_sel   <= w_mem_sel_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_i_ack     <= w_i_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
    end
  end

  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_sel   = r_mem_sel;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;

  // Drops in the ack cycle so the pipeline can advance together with the completion.
  assign stall_req = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Bench for sopc_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level model with its own shadow memory.
module tb_sopc_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = 1;
`ifdef SOPC_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_sel;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ack, d_ack, mem_ce, mem_we, stall_req;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_sel;

  always #5 clk = ~clk;

  sopc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .stall_req(stall_req)
  );

  function automatic logic [31:0] ram_init(input int i);
    if (i == 1)  return 32'h3401_1100;
    if (i == 32) return 32'h1122_3344;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Simple SRAM: read data presented while selected, byte writes on the clock edge.
  logic [31:0] ram [64];
  logic        ram_load;
  assign mem_rdata = mem_ce ? ram[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= ram_init(i);
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) ram[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts negedges until the selected ack; a bound expiry is a failed comparison.
  task automatic wait_ack(input bit is_d, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((is_d && d_ack) || (!is_d && i_ack)) break;
      if (cyc > 50) begin
        checks++;
        errors++;
        $display("FAIL wait_ack timeout: got no ack expected ack within 50 cycles");
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] exp_d_prev;
  logic [31:0] shadow [64];
  int          cyc;

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"fetch_4",     1'b0, 1'b0, 32'h04, 32'h0,         4'hF, 32'h3401_1100};
    vecs[1] = '{"store_80",    1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'h3, 32'h0};
    vecs[2] = '{"load_80",     1'b1, 1'b0, 32'h80, 32'h0,         4'hF, 32'h1122_BEEF};
    vecs[3] = '{"fetch_80",    1'b0, 1'b0, 32'h80, 32'h0,         4'hF, 32'h1122_BEEF};
    vecs[4] = '{"load_8",      1'b1, 1'b0, 32'h08, 32'h0,         4'hC, 32'hA500_0002};
    vecs[5] = '{"store_8",     1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[6] = '{"fetch_8",     1'b0, 1'b0, 32'h08, 32'h0,         4'hF, 32'hCAFE_F00D};

    // Reset held with a pending fetch
    rst = 1'b0; ram_load = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
    exp_d_prev = 32'h0;
    repeat (2) @(negedge clk);
    ram_load = 1'b0;
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd1);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b1;
    wait_ack(1'b0, cyc);
    chk("rst_first_ack_cycle", 32'(cyc), 32'(W + 2));
    chk("rst_first_rdata", i_rdata, 32'hA500_0000);
    i_req = 1'b0;
    @(negedge clk);

    // Directed single transactions
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].is_d) begin
        d_req = 1'b1; d_we = vecs[k].we; d_addr = vecs[k].addr;
        d_wdata = vecs[k].wdata; d_sel = vecs[k].sel;
      end else begin
        i_req = 1'b1; i_addr = vecs[k].addr;
      end
      for (int c = 1; c <= int'(W) + 3; c++) begin
        @(negedge clk);
        if (c <= int'(W) + 1) begin
          chk({vecs[k].name, "_ce"}, 32'(mem_ce), 32'd1);
          chk({vecs[k].name, "_addr"}, mem_addr, vecs[k].addr);
          chk({vecs[k].name, "_sel"}, 32'(mem_sel), 32'(vecs[k].sel));
          chk({vecs[k].name, "_we"}, 32'(mem_we), 32'(vecs[k].we));
          if (vecs[k].we) chk({vecs[k].name, "_wdata"}, mem_wdata, vecs[k].wdata);
          chk({vecs[k].name, "_stall"}, 32'(stall_req), 32'd1);
        end else if (c == int'(W) + 2) begin
          chk({vecs[k].name, "_ce_off"}, 32'(mem_ce), 32'd0);
          chk({vecs[k].name, "_iack"}, 32'(i_ack), 32'(!vecs[k].is_d));
          chk({vecs[k].name, "_dack"}, 32'(d_ack), 32'(vecs[k].is_d));
          chk({vecs[k].name, "_stall_ack"}, 32'(stall_req), 32'd0);
          if (!vecs[k].is_d) begin
            chk({vecs[k].name, "_rdata"}, i_rdata, vecs[k].rdata);
          end else if (vecs[k].we) begin
            chk({vecs[k].name, "_rdata_hold"}, d_rdata, exp_d_prev);
          end else begin
            chk({vecs[k].name, "_rdata"}, d_rdata, vecs[k].rdata);
            exp_d_prev = vecs[k].rdata;
          end
          i_req = 1'b0; d_req = 1'b0;
        end else begin
          chk({vecs[k].name, "_idle_ack"}, 32'(i_ack | d_ack), 32'd0);
        end
      end
    end

    // Contention: data first, then the fetch in the next IDLE
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C; d_sel = 4'hF;
    i_req = 1'b1; i_addr = 32'h10;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("cont_dack", 32'(d_ack), 32'(c == 3));
      chk("cont_iack", 32'(i_ack), 32'(c == 7));
      chk("cont_stall", 32'(stall_req), 32'(c < 7));
      if (c == 3) begin
        chk("cont_d_rdata", d_rdata, 32'hA500_0003);
        d_req = 1'b0;
      end
      if (c == 7) begin
        chk("cont_i_rdata", i_rdata, 32'hA500_0004);
        i_req = 1'b0;
      end
    end
    @(negedge clk);

    // Both masters hold their requests across four accesses
    begin
      bit got [4];
      int n_acks = 0;
      d_req = 1'b1; i_req = 1'b1;
      for (int c = 0; c < 40 && n_acks < 4; c++) begin
        @(negedge clk);
        if (d_ack || i_ack) begin
          got[n_acks] = d_ack;
          n_acks++;
        end
      end
      chk("hold_ack_count", 32'(n_acks), 32'd4);
      for (int g = 0; g < 4; g++)
        chk($sformatf("hold_grant%0d_is_data", g), 32'(got[g]), 32'(RR ? (g % 2 == 0) : 1'b1));
      d_req = 1'b0; i_req = 1'b0;
      @(negedge clk);
    end

    // Fetch request withdrawn during ACCESS still completes
    i_req = 1'b1; i_addr = 32'h14;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) i_req = 1'b0;
      chk("drop_acc_iack", 32'(i_ack), 32'(c == 3));
    end
    chk("drop_acc_rdata", i_rdata, 32'hA500_0005);

    // Fetch request withdrawn before it is granted issues nothing
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h18; d_sel = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("drop_pre_dack", 32'(d_ack), 32'(c == 3));
      chk("drop_pre_iack", 32'(i_ack), 32'd0);
      chk("drop_pre_ce", 32'(mem_ce), 32'(c <= 2));
      if (c == 1) i_req = 1'b1;
      if (c == 2) i_req = 1'b0;
      if (c == 3) d_req = 1'b0;
    end

    // Reset in the second ACCESS cycle aborts without ack, then the fetch restarts
    i_req = 1'b1; i_addr = 32'h04;
    @(negedge clk);
    chk("mid_rst_ce1", 32'(mem_ce), 32'd1);
    @(negedge clk);
    chk("mid_rst_ce2", 32'(mem_ce), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ce_async", 32'(mem_ce), 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    chk("mid_rst_no_ack", 32'(i_ack), 32'd0);
    rst = 1'b1;
    wait_ack(1'b0, cyc);
    chk("mid_rst_restart_cycle", 32'(cyc), 32'(W + 2));
    chk("mid_rst_restart_rdata", i_rdata, 32'h3401_1100);
    i_req = 1'b0;
    @(negedge clk);

    // Randomized traffic against a transaction-level model (words 48..63 only)
    begin
      int          free_at = 0, ack_at = -10, acc_lo = -10;
      bit          g_d = 1'b0, g_we = 1'b0, m_last_d = 1'b0, pick_d, in_acc, e_ia, e_da;
      logic [31:0] g_addr = 32'h0, g_wdata = 32'h0, exp_rd = 32'h0;
      logic [3:0]  g_sel = 4'h0;
      int          idx;
      for (int i = 0; i < 64; i++) shadow[i] = ram_init(i);
      for (int n = 0; n < 800; n++) begin
        @(negedge clk);
        in_acc = (n >= acc_lo) && (n < ack_at);
        e_ia   = (n == ack_at) && !g_d;
        e_da   = (n == ack_at) && g_d;
        chk("rnd_ce", 32'(mem_ce), 32'(in_acc));
        if (in_acc) begin
          chk("rnd_addr", mem_addr, g_addr);
          chk("rnd_sel", 32'(mem_sel), 32'(g_sel));
          chk("rnd_we", 32'(mem_we), 32'(g_we));
          if (g_we) chk("rnd_wdata", mem_wdata, g_wdata);
        end
        chk("rnd_iack", 32'(i_ack), 32'(e_ia));
        chk("rnd_dack", 32'(d_ack), 32'(e_da));
        if (e_ia) chk("rnd_i_rdata", i_rdata, exp_rd);
        if (e_da && !g_we) chk("rnd_d_rdata", d_rdata, exp_rd);
        chk("rnd_stall", 32'(stall_req), 32'((i_req && !e_ia) || (d_req && !e_da)));

        if (e_ia) i_req = 1'b0;
        else if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1'b1; i_addr = 32'((48 + $urandom_range(0, 15)) * 4);
        end
        if (e_da) d_req = 1'b0;
        else if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = 32'((48 + $urandom_range(0, 15)) * 4);
          d_wdata = $urandom; d_sel = 4'($urandom_range(0, 15));
        end

        if (n >= free_at && (i_req || d_req)) begin
          pick_d = (i_req && d_req) ? (RR ? !m_last_d : 1'b1) : d_req;
          m_last_d = pick_d;
          g_d = pick_d;
          g_we = pick_d ? d_we : 1'b0;
          g_addr = pick_d ? d_addr : i_addr;
          g_sel = pick_d ? d_sel : 4'hF;
          g_wdata = d_wdata;
          acc_lo = n + 1; ack_at = n + 2 + int'(W); free_at = n + 3 + int'(W);
          idx = int'(g_addr[7:2]);
          if (g_we) begin
            for (int b = 0; b < 4; b++)
              if (g_sel[b]) shadow[idx][b*8 +: 8] = g_wdata[b*8 +: 8];
          end else begin
            exp_rd = shadow[idx];
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
